// File: rtl/i2c_master_tx.sv
// Write-only I2C bus master: START, 7-bit address + W, data bytes with ACK checks, STOP.
// SCL/SDA are open-drain style drives (0 = pull low, 1 = release).
module i2c_master_tx #(
    parameter int QDIV = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_req,
    input  logic [6:0] slave_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_ADDR     = 3'd2;
    localparam logic [2:0] S_ADDR_ACK = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_DATA     = 3'd5;
    localparam logic [2:0] S_DATA_ACK = 3'd6;
    localparam logic [2:0] S_STOP     = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic          nack_seen_q, nack_seen_d;
    logic          scl_q, scl_d, sda_q, sda_d;
    logic          busy_q, busy_d, done_q, done_d, nack_q, nack_d;
    logic          qend, slot_end;

    assign qend     = (qcnt_q == QLAST);
    assign slot_end = qend && (phase_q == 2'd3);

    // Next-state, timing counters and per-transaction bookkeeping
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        byte_d      = byte_q;
        last_d      = last_q;
        nack_seen_d = nack_seen_q;
        nack_d      = 1'b0;
        done_d      = 1'b0;

        // Quarter/phase timers freeze while idle or stretching SCL for data
        if (state_q == S_IDLE || state_q == S_WAIT) begin
            qcnt_d  = qcnt_q;
            phase_d = phase_q;
        end else if (qend) begin
            qcnt_d  = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            qcnt_d  = qcnt_q + QW'(1);
            phase_d = phase_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d     = S_START;
                    byte_d      = {slave_addr, 1'b0};
                    nack_seen_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_ADDR;
                end else begin
                    state_d = S_START;
                end
            end
            S_ADDR, S_DATA: begin
                if (slot_end) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                if (qend && phase_q == 2'd2 && sda_in) begin
                    nack_d      = 1'b1;
                    nack_seen_d = 1'b1;
                end else begin
                    nack_d = 1'b0;
                end
                if (slot_end) begin
                    if (nack_seen_q) begin
                        state_d = S_STOP;
                    end else if (state_q == S_ADDR_ACK || !last_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT: begin
                if (tx_valid) begin
                    state_d = S_DATA;
                    byte_d  = tx_data;
                    last_d  = tx_last;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    state_d = S_IDLE;
                    done_d  = !nack_seen_q;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus levels derived from the upcoming state so the drives are registered
    always_comb begin
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_IDLE: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
            S_START: begin
                scl_d = (phase_d != 2'd3);
                sda_d = (phase_d < 2'd2);
            end
            S_ADDR, S_DATA: begin
                scl_d = phase_d[1];
                sda_d = byte_d[3'd7 - bitcnt_d];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_d = phase_d[1];
                sda_d = 1'b1;
            end
            S_WAIT: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
            S_STOP: begin
                scl_d = (phase_d != 2'd0);
                sda_d = phase_d[1];
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            phase_q     <= 2'd0;
            bitcnt_q    <= 3'd0;
            byte_q      <= 8'd0;
            last_q      <= 1'b0;
            nack_seen_q <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            phase_q     <= phase_d;
            bitcnt_q    <= bitcnt_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            nack_seen_q <= nack_seen_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            nack_q      <= nack_d;
        end
    end

    // Byte handshake completes in the same cycle tx_valid is seen in WAIT
    assign tx_ready = (state_q == S_WAIT) && tx_valid;
    assign scl_out  = scl_q;
    assign sda_out  = sda_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack     = nack_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Randomized bench for i2c_master_tx: bus decoder, ACKing slave and timing model per transaction.
module tb_i2c_master_tx;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [1:0] start_v = 2'b00;
    logic [6:0] slave_addr = 7'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       slave_sda = 1'b1;
    logic [1:0] scl_o, sda_o, busy_o, done_o, nack_o, rdy_o, sda_in_v;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] bytes [8];
    int dly [8];

    always #5 clk = ~clk;

    assign sda_in_v = sda_o & {2{slave_sda}};

    i2c_master_tx #(.QDIV(2)) u_q2 (
        .clk(clk), .n_rst(n_rst), .start_req(start_v[0]), .slave_addr(slave_addr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(rdy_o[0]),
        .sda_in(sda_in_v[0]), .scl_out(scl_o[0]), .sda_out(sda_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .nack(nack_o[0])
    );

    i2c_master_tx #(.QDIV(1)) u_q1 (
        .clk(clk), .n_rst(n_rst), .start_req(start_v[1]), .slave_addr(slave_addr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(rdy_o[1]),
        .sda_in(sda_in_v[1]), .scl_out(scl_o[1]), .sda_out(sda_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .nack(nack_o[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            start_v   = 2'b00;
            tx_valid  = 1'b0;
            n_rst     = 1'b0;
            slave_sda = 1'b1;
        end
    endtask

    // One transaction; nack_at: 0 = address NACKed, j+1 = data byte j NACKed, >nb = all ACKed.
    // Cycle index n counts samples after the edge that accepts start_req.
    task automatic run_txn(input int sel, input int q, input logic [6:0] addr,
                           input int nb, input int nack_at, input int abort_at);
        int n, t_m, src_j, src_v, exp_w, exp_a, exp_end, exp_nack, sent, rises;
        int starts, stops, rdy_cnt, done_cnt, nack_cnt;
        logic pscl, pbus, scl, bus, slave_low, ended;
        logic [7:0] got_b, exp_b;
        logic bits [$];

        sent  = (nack_at <= nb) ? nack_at : nb;
        rises = 0; starts = 0; stops = 0; rdy_cnt = 0; done_cnt = 0; nack_cnt = 0;
        exp_a = -1; exp_w = -1; exp_nack = -1; exp_end = -1;
        src_j = 0; src_v = 0;
        t_m = 40 * q;
        if (nack_at == 0) begin
            exp_nack = 39 * q;
            exp_end  = 44 * q;
        end else begin
            src_v = t_m + dly[0];
            if (src_v < 0) src_v = 0;
            exp_w = t_m;
            exp_a = (t_m > src_v) ? t_m : src_v;
            t_m   = exp_a + 1 + 36 * q;
            if (nack_at == 1) begin
                exp_nack = exp_a + 1 + 35 * q;
                exp_end  = exp_a + 1 + 40 * q;
            end else if (nb == 1) begin
                exp_end = t_m + 4 * q;
            end
        end

        @(negedge clk);
        start_v[sel] = 1'b1;
        slave_addr   = addr;
        tx_valid     = 1'b1;
        tx_data      = 8'($urandom);
        tx_last      = 1'b0;
        slave_sda    = 1'b1;
        pscl = 1'b1; pbus = 1'b1; ended = 1'b0; n = 0;

        while (!ended) begin
            @(negedge clk);
            start_v = 2'b00;
            if (n >= 1 && n <= 30) begin
                start_v[sel] = 1'($urandom_range(0, 1));
                slave_addr   = 7'($urandom);
            end
            n_rst = (abort_at >= 0) && (n == abort_at || n == abort_at + 1);
            if (src_j < sent && n >= src_v) begin
                tx_valid = 1'b1;
                tx_data  = bytes[src_j];
                tx_last  = (src_j == nb - 1);
            end else begin
                tx_valid = (n < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end
            slave_low = 1'b0;
            if (rises % 9 == 8 && !pscl && rises / 9 != nack_at) slave_low = 1'b1;
            if (rises % 9 == 0 && rises > 0 && pscl && rises / 9 - 1 != nack_at) slave_low = 1'b1;
            slave_sda = !slave_low;
            #1;
            scl = scl_o[sel];
            bus = sda_o[sel] & slave_sda;

            if (abort_at >= 0 && n == abort_at + 1) begin
                check("rst_scl", scl_o[sel], 1);
                check("rst_sda", sda_o[sel], 1);
                check("rst_busy", busy_o[sel], 0);
                check("rst_ready", rdy_o[sel], 0);
                check("rst_done", done_o[sel], 0);
            end
            if (abort_at >= 0 && n == abort_at + 2) begin
                check("rst_busy_hold", busy_o[sel], 0);
                ended = 1'b1;
            end else begin
                if (n == 0) check("busy_rise", busy_o[sel], 1);
                if (src_j < sent && n >= exp_w && n < exp_a) check("stretch_scl", scl, 0);
                if (pscl && scl && (pbus != bus)) begin
                    if (!bus) begin
                        starts++;
                        bits.delete();
                        rises = 0;
                    end else begin
                        stops++;
                        if (bits.size() > 0) bits.delete(bits.size() - 1);
                    end
                end else if (!pscl && scl) begin
                    bits.push_back(bus);
                    rises++;
                end
                if (rdy_o[sel]) begin
                    rdy_cnt++;
                    check("ready_time", n, exp_a);
                    src_j++;
                    if (src_j < sent) begin
                        src_v = t_m + dly[src_j];
                        if (src_v < n + 1) src_v = n + 1;
                        exp_w = t_m;
                        exp_a = (t_m > src_v) ? t_m : src_v;
                        t_m   = exp_a + 1 + 36 * q;
                        if (src_j + 1 == nack_at) begin
                            exp_nack = exp_a + 1 + 35 * q;
                            exp_end  = exp_a + 1 + 40 * q;
                        end else if (src_j == nb - 1) begin
                            exp_end = t_m + 4 * q;
                        end
                    end
                end
                if (nack_o[sel]) begin
                    nack_cnt++;
                    check("nack_time", n, exp_nack);
                end
                if (done_o[sel]) done_cnt++;
                if (n > 0 && !busy_o[sel] && abort_at < 0) begin
                    check("end_time", n, exp_end);
                    check("done_at_end", done_o[sel], (nack_at > nb) ? 1 : 0);
                    ended = 1'b1;
                end else if (n > 4000) begin
                    check("timeout", n, exp_end);
                    ended = 1'b1;
                end
            end
            pscl = scl;
            pbus = bus;
            n++;
        end

        if (abort_at < 0) begin
            check("ready_count", rdy_cnt, sent);
            check("done_count", done_cnt, (nack_at > nb) ? 1 : 0);
            check("nack_count", nack_cnt, (nack_at <= nb) ? 1 : 0);
            check("start_conds", starts, 1);
            check("stop_conds", stops, 1);
            check("bit_count", bits.size(), 9 * (sent + 1));
            if (bits.size() == 9 * (sent + 1)) begin
                for (int b = 0; b <= sent; b++) begin
                    got_b = 8'd0;
                    for (int i = 0; i < 8; i++) got_b = {got_b[6:0], bits[9 * b + i]};
                    exp_b = (b == 0) ? {addr, 1'b0} : bytes[b - 1];
                    check("bus_byte", got_b, exp_b);
                    check("bus_ack", bits[9 * b + 8], (b == nack_at) ? 1 : 0);
                end
            end
        end
        idle(4);
    endtask

    initial begin
        int nb, nk;
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("init_scl", scl_o, 3);
        check("init_sda", sda_o, 3);
        check("init_busy", busy_o, 0);
        check("init_done", done_o, 0);
        check("init_nack", nack_o, 0);
        idle(3);

        for (int i = 0; i < 8; i++) dly[i] = 0;
        bytes[0] = 8'hA5;
        run_txn(0, 2, 7'h78, 1, 99, -1);
        run_txn(0, 2, 7'h78, 1, 0, -1);
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        dly[1] = 20;
        run_txn(0, 2, 7'h2C, 3, 99, -1);
        dly[1] = 0;
        run_txn(0, 2, 7'h55, 2, 99, 100);
        bytes[0] = 8'hA5;
        run_txn(1, 1, 7'h78, 1, 99, -1);

        for (int r = 0; r < 8; r++) begin
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) begin
                bytes[i] = 8'($urandom);
                dly[i]   = $urandom_range(0, 15) - 10;
            end
            nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb) : 99;
            run_txn(r % 2, (r % 2 == 0) ? 2 : 1, 7'($urandom), nb, nk, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
